e_enum_serializer: RTL

- Transmit side of the tagged-variant path. Accepts one enum value per transaction (8-bit tag plus payload) and emits it as a byte stream over a valid/ready lane.
- Byte order: tag first, then payload bytes LSB-first. The payload length depends on the variant.
- The downstream match/decode logic consumes this stream. The block sits between the variant producer and the byte link.

---
 rtl/e_enum_serializer_pkg.sv | 39 +++
 rtl/e_enum_serializer_byte_select.sv | 28 ++
 rtl/e_enum_serializer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/e_enum_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e_enum_serializer_pkg
// Description : Shared tag constants, state encoding and variant helpers for
//               the tagged-variant byte serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package e_enum_serializer_pkg;

    // Variant tags carried in the first byte of every frame
    localparam logic [7:0] c_V_NONE       = 8'd0;
    localparam logic [7:0] c_V_SHORT      = 8'd1;
    localparam logic [7:0] c_V_FULL       = 8'd2;
    localparam int         c_NUM_VARIANTS = 3;

    // Serializer state encoding
    localparam int c_ST_W = 2;
    typedef logic [c_ST_W-1:0] state_t;
    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_TAG     = 2'd1;
    localparam state_t c_ST_PAYLOAD = 2'd2;

    // True for tags that name a known variant
    function automatic logic tag_legal(input logic [7:0] tag);
        return (tag < 8'(c_NUM_VARIANTS));
    endfunction

    // Payload byte count for a tag; illegal tags report zero
    function automatic int variant_len(input logic [7:0] tag, input int full_len);
        case (tag)
            c_V_NONE:  return 0;
            c_V_SHORT: return 1;
            c_V_FULL:  return full_len;
            default:   return 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_enum_serializer_byte_select.sv
`default_nettype none
// ============================================================================
// Module      : e_byte_select
// Description : Combinational byte mux picking payload byte idx (byte 0 is
//               bits [7:0]). Indices past the payload return zero.
// Revision    : 1.0 - initial release
// ============================================================================
module e_byte_select #(
    parameter int PAYLOAD_BYTES = 2,
    parameter int IDX_W         = 2
) (
    input  logic [8*PAYLOAD_BYTES-1:0] i_payload,
    input  logic [IDX_W-1:0]           i_idx,
    output logic [7:0]                 o_byte
);

    // Walk the payload bytes and forward the one whose position matches idx
    always_comb begin
        o_byte = 8'h00;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_byte = i_payload[i*8 +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/e_enum_serializer.sv
`default_nettype none
// ============================================================================
// Module      : e_enum_serializer
// Description : Accepts one tagged variant per transaction and emits it as a
//               byte stream (tag first, payload LSB-first) over valid/ready.
//               Illegal tags are consumed and flagged with a one-cycle err_o.
// Revision    : 1.0 - initial release
// ============================================================================
module e_enum_serializer
    import e_enum_serializer_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 2,
    parameter int FRAME_CNT_W   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [7:0]                 tag_i,
    input  logic [8*PAYLOAD_BYTES-1:0] payload_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [7:0]                 out_byte_o,
    output logic                       out_last_o,
    output logic                       err_o,
    output logic [FRAME_CNT_W-1:0]     frames_o
);

    // idx must hold 0..PAYLOAD_BYTES so len fits in the same width
    localparam int c_IDX_W = $clog2(PAYLOAD_BYTES + 1);

    state_t                       r_state;
    state_t                       w_next_state;
    logic [7:0]                   r_tag;
    logic [8*PAYLOAD_BYTES-1:0]   r_payload;
    logic [c_IDX_W-1:0]           r_len;
    logic [c_IDX_W-1:0]           r_idx;
    logic                         r_err;
    logic [FRAME_CNT_W-1:0]       r_frames;

    logic                         w_legal;
    logic                         w_accept;
    logic                         w_last_hs;
    logic [7:0]                   w_sel_byte;

    assign w_legal   = tag_legal(tag_i);
    assign w_accept  = in_valid_i && (r_state == c_ST_IDLE);
    assign w_last_hs = out_valid_o && out_ready_i && out_last_o;

    assign err_o    = r_err;
    assign frames_o = r_frames;

    e_byte_select #(
        .PAYLOAD_BYTES (PAYLOAD_BYTES),
        .IDX_W         (c_IDX_W)
    ) u_byte_select (
        .i_payload (r_payload),
        .i_idx     (r_idx),
        .o_byte    (w_sel_byte)
    );

    // State register; reset abandons any frame in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and stream outputs; outputs depend only on registered state
    always_comb begin
        w_next_state = r_state;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        out_byte_o   = 8'h00;
        out_last_o   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i && w_legal) begin
                    w_next_state = c_ST_TAG;
                end
            end
            c_ST_TAG: begin
                out_valid_o = 1'b1;
                out_byte_o  = r_tag;
                out_last_o  = (r_len == '0);
                if (out_ready_i) begin
                    w_next_state = (r_len == '0) ? c_ST_IDLE : c_ST_PAYLOAD;
                end
            end
            c_ST_PAYLOAD: begin
                out_valid_o = 1'b1;
                out_byte_o  = w_sel_byte;
                out_last_o  = (r_idx == (r_len - c_IDX_W'(1)));
                if (out_ready_i && out_last_o) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Frame latch, byte index, error pulse and completed-frame counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tag     <= 8'h00;
            r_payload <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_frames  <= '0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_tag     <= tag_i;
                r_payload <= payload_i;
                r_len     <= c_IDX_W'(variant_len(tag_i, PAYLOAD_BYTES));
                r_idx     <= '0;
            end
            if ((r_state == c_ST_TAG) && out_ready_i) begin
                r_idx <= '0;
            end
            if ((r_state == c_ST_PAYLOAD) && out_ready_i && !out_last_o) begin
                r_idx <= r_idx + c_IDX_W'(1);
            end
            if (w_last_hs) begin
                r_frames <= r_frames + FRAME_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
